clock_time_ctrl: RTL

- Sequencing controller for the digital-clock counter chain: seconds units (mod-10), seconds tens (mod-6), minutes units/tens, hours (mod-24).
- Turns the 1 Hz tick into one-cycle count enables with correct carry cascade.
- Runs a mode FSM for manual hour/minute setting: adjust with auto-repeat, blink masks for the display, inactivity timeout.
- Sits between the button debouncers / 1 Hz divider and the counter instances.

---
 rtl/clock_time_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the digital-clock counter chain: tick carry cascade,
// RUN/SET_HR/SET_MIN mode FSM with adjust auto-repeat, blink masks and set-mode timeout.
module clock_time_ctrl #(
  parameter int REPEAT_DLY    = 2,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_adj,
  input  logic       btn_adj_lvl,
  input  logic [3:0] sec_lo,
  input  logic [3:0] sec_hi,
  input  logic [3:0] min_lo,
  input  logic [3:0] min_hi,
  output logic       en_sec_lo,
  output logic       en_sec_hi,
  output logic       en_min_lo,
  output logic       en_min_hi,
  output logic       en_hr,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink_hr,
  output logic       blink_min
);

  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} mode_e;

  mode_e       mode_q, mode_d;
  logic        phase_q, phase_d;
  logic [3:0]  rep_q, rep_d;
  logic [5:0]  to_q, to_d;
  logic        busy_q;
  logic [4:0]  en_q, en_d;   // {sec_lo, sec_hi, min_lo, min_hi, hr}
  logic        clr_q, clr_d;
  logic        bhr_q, bmin_q;
  logic        sec59, min59, rep_ev, tmo, adj;

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    to_d    = to_q;
    en_d    = '0;
    clr_d   = 1'b0;
    sec59   = (sec_hi == 4'd5) && (sec_lo == 4'd9);
    min59   = (min_hi == 4'd5) && (min_lo == 4'd9);
    rep_ev  = tick && btn_adj_lvl && (rep_q == 4'(REPEAT_DLY));
    tmo     = tick && !btn_mode && !btn_adj && !btn_adj_lvl && (to_q == 6'(TIMEOUT_TICKS - 1));
    // busy_q drops adjusts while the counters still show pre-increment digits
    adj     = (mode_q != RUN) && !btn_mode && !tmo && (btn_adj || rep_ev) && !busy_q;
    case (mode_q)
      RUN: begin
        rep_d   = '0;
        to_d    = '0;
        phase_d = 1'b0;
        if (tick)
          en_d = {1'b1, sec_lo == 4'd9, sec59, sec59 && (min_lo == 4'd9), sec59 && min59};
        if (btn_mode) mode_d = SET_HR;
      end
      default: begin
        if (!btn_adj_lvl)                           rep_d = '0;
        else if (tick && rep_q != 4'(REPEAT_DLY)) rep_d = rep_q + 4'd1;
        if (btn_mode || btn_adj || btn_adj_lvl) to_d = '0;
        else if (tick)                          to_d = to_q + 6'd1;
        if (tick) phase_d = ~phase_q;
        if (btn_mode) begin
          mode_d  = (mode_q == SET_HR) ? SET_MIN : RUN;
          clr_d   = (mode_q != SET_HR);
          phase_d = 1'b0;
          rep_d   = '0;
          to_d    = '0;
        end else if (tmo) begin
          mode_d  = RUN;
          clr_d   = 1'b1;
          phase_d = 1'b0;
          rep_d   = '0;
          to_d    = '0;
        end
        // minutes adjust wraps without hour carry
        if (adj)
          en_d = (mode_q == SET_HR) ? 5'b00001 : {2'b00, 1'b1, min_lo == 4'd9, 1'b0};
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (!nCR) begin
      mode_q  <= RUN;
      phase_q <= 1'b0;
      rep_q   <= '0;
      to_q    <= '0;
      busy_q  <= 1'b0;
      en_q    <= '0;
      clr_q   <= 1'b0;
      bhr_q   <= 1'b0;
      bmin_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      to_q    <= to_d;
      busy_q  <= |en_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      bhr_q   <= phase_d && (mode_d == SET_HR);
      bmin_q  <= phase_d && (mode_d == SET_MIN);
    end
  end

  assign {en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr} = en_q;
  assign sec_clr   = clr_q;
  assign mode      = mode_q;
  assign blink_hr  = bhr_q;
  assign blink_min = bmin_q;

endmodule
